// File: rtl/nes_mem_sched.sv
// Shared SDRAM port scheduler: 4-phase NES slot timing, loader write FIFO
// committed one byte per slot, then hand-over of the port to the NES bus.
module nes_mem_sched #(
    parameter int ADDR_BITS  = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_done,
    input  logic                 ld_valid,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [7:0]           ld_data,
    output logic                 ld_ready,
    input  logic [ADDR_BITS-1:0] nes_addr,
    input  logic                 nes_rd_cpu,
    input  logic                 nes_rd_ppu,
    input  logic                 nes_wr,
    input  logic [7:0]           nes_dout,
    output logic [1:0]           phase,
    output logic                 run_nes,
    output logic                 clkref,
    output logic                 nes_reset,
    output logic [ADDR_BITS+2:0] sd_addr,
    output logic                 sd_we,
    output logic                 sd_oeA,
    output logic                 sd_oeB,
    output logic [7:0]           sd_din,
    output logic [ADDR_BITS-1:0] wr_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = ADDR_BITS + 8;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [AW:0]          PTR_ONE = (AW + 1)'(1);
    localparam logic [ADDR_BITS-1:0] CNT_ONE = ADDR_BITS'(1);

    logic [1:0]           state;
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 slot;
    logic                 committing;
    logic                 load_done_q;
    logic                 fall_pend;
    logic                 load_fall;
    logic [ADDR_BITS-1:0] wr_addr_p0;
    logic [7:0]           wr_data_p0;
    logic                 vld_p0;

    assign slot       = (phase == 2'd3);
    assign run_nes    = slot;
    assign clkref     = phase[1];
    assign nes_reset  = (state != ST_RUN);
    assign committing = (state == ST_LOAD) || (state == ST_DRAIN);

    // Full is judged before any same-cycle pop, so ld_ready stays low then.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign ld_ready = (state == ST_LOAD) && !full;
    assign push     = ld_valid && ld_ready;
    assign pop      = slot && committing && !empty;
    assign head     = fifo_mem[rptr[AW-1:0]];
    assign load_fall = load_done_q && !load_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wptr[AW-1:0]] <= {ld_addr, ld_data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // FIFO head -> write register (p0): one commit per slot edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            wr_addr_p0  <= '0;
            wr_data_p0  <= '0;
            vld_p0      <= 1'b0;
            wr_count    <= '0;
            load_done_q <= 1'b0;
            fall_pend   <= 1'b0;
        end else begin
            load_done_q <= load_done;
            if (committing && slot) begin
                if (!empty) begin
                    wr_addr_p0 <= head[EW-1:8];
                    wr_data_p0 <= head[7:0];
                    vld_p0     <= 1'b1;
                    if (wr_count != '1) wr_count <= wr_count + CNT_ONE;
                end else begin
                    vld_p0 <= 1'b0;
                end
            end
            case (state)
                ST_LOAD: begin
                    if (load_done) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (slot && empty) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (slot && (fall_pend || load_fall)) begin
                        state     <= ST_LOAD;
                        wr_count  <= '0;
                        vld_p0    <= 1'b0;
                        fall_pend <= 1'b0;
                    end else if (load_fall) begin
                        fall_pend <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    always_comb begin
        sd_addr = {3'b000, wr_addr_p0};
        sd_din  = wr_data_p0;
        sd_we   = vld_p0;
        sd_oeA  = 1'b0;
        sd_oeB  = 1'b0;
        if (state == ST_RUN) begin
            sd_addr = {3'b000, nes_addr};
            sd_din  = nes_dout;
            sd_we   = nes_wr;
            sd_oeA  = nes_rd_cpu;
            sd_oeB  = nes_rd_ppu;
        end
    end

endmodule

// File: tb/tb_nes_mem_sched.sv
// Randomized bench for nes_mem_sched against a queue-based slot model.
module tb_nes_mem_sched;

    localparam int AB = 22;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_done, ld_valid, ld_ready;
    logic [AB-1:0] ld_addr, nes_addr, wr_count;
    logic [7:0]    ld_data, nes_dout, sd_din;
    logic          nes_rd_cpu, nes_rd_ppu, nes_wr;
    logic [1:0]    phase;
    logic          run_nes, clkref, nes_reset, sd_we, sd_oeA, sd_oeB;
    logic [AB+2:0] sd_addr;

    nes_mem_sched #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .load_done(load_done),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .nes_addr(nes_addr), .nes_rd_cpu(nes_rd_cpu), .nes_rd_ppu(nes_rd_ppu),
        .nes_wr(nes_wr), .nes_dout(nes_dout), .phase(phase), .run_nes(run_nes),
        .clkref(clkref), .nes_reset(nes_reset), .sd_addr(sd_addr), .sd_we(sd_we),
        .sd_oeA(sd_oeA), .sd_oeB(sd_oeB), .sd_din(sd_din), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    typedef enum int {M_LOAD, M_DRAIN, M_RUN} mst_t;
    mst_t            m_st;
    logic [AB+7:0]   m_q[$];
    int              m_phase;
    bit              m_we, m_fall, m_ld_prev;
    logic [AB-1:0]   m_addr, m_cnt;
    logic [7:0]      m_data;
    int              pushed;

    task automatic model_reset();
        m_st = M_LOAD; m_q.delete(); m_phase = 0; m_we = 0; m_fall = 0;
        m_ld_prev = 0; m_addr = '0; m_cnt = '0; m_data = '0;
    endtask

    function automatic bit model_accepts();
        return ld_valid && (m_st == M_LOAD) && (m_q.size() < FD);
    endfunction

    task automatic model_step();
        bit slot, had, acc, fell;
        logic [AB+7:0] e;
        slot = (m_phase == 3);
        had  = (m_q.size() > 0);
        acc  = model_accepts();
        fell = m_ld_prev && !load_done;
        if (m_st == M_LOAD || m_st == M_DRAIN) begin
            if (slot) begin
                if (had) begin
                    e = m_q.pop_front();
                    m_addr = e[AB+7:8]; m_data = e[7:0]; m_we = 1;
                    if (m_cnt != {AB{1'b1}}) m_cnt = m_cnt + 1;
                end else begin
                    m_we = 0;
                end
            end
            if (m_st == M_LOAD && load_done) m_st = M_DRAIN;
            else if (m_st == M_DRAIN && slot && !had) m_st = M_RUN;
        end else begin
            if (slot && (m_fall || fell)) begin
                m_st = M_LOAD; m_cnt = '0; m_we = 0; m_fall = 0;
            end else if (fell) begin
                m_fall = 1;
            end
        end
        if (acc) m_q.push_back({ld_addr, ld_data});
        m_ld_prev = load_done;
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic check_outputs();
        bit run;
        run = (m_st == M_RUN);
        chk("phase", phase, m_phase);
        chk("run_nes", run_nes, m_phase == 3);
        chk("clkref", clkref, m_phase >= 2);
        chk("nes_reset", nes_reset, !run);
        chk("ld_ready", ld_ready, (m_st == M_LOAD) && (m_q.size() < FD));
        chk("wr_count", wr_count, m_cnt);
        chk("sd_we", sd_we, run ? nes_wr : m_we);
        chk("sd_addr", sd_addr, run ? {3'b000, nes_addr} : {3'b000, m_addr});
        chk("sd_din", sd_din, run ? nes_dout : m_data);
        chk("sd_oeA", sd_oeA, run ? nes_rd_cpu : 1'b0);
        chk("sd_oeB", sd_oeB, run ? nes_rd_ppu : 1'b0);
    endtask

    task automatic tick();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic new_byte();
        ld_addr = AB'($urandom);
        ld_data = 8'($urandom);
    endtask

    // loader holds ld_valid until accepted
    task automatic rand_traffic(input int n);
        bit hs;
        for (int i = 0; i < n; i++) begin
            if (!ld_valid) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                new_byte();
            end
            hs = model_accepts();
            tick();
            if (hs) begin
                pushed++;
                ld_valid = 1'b0;
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic drain_idle();
        int k;
        k = 0;
        while ((m_q.size() > 0 || m_we) && k < 60) begin
            tick();
            k++;
        end
        chk("drain_timeout", k < 60, 1'b1);
    endtask

    int  hi_cnt, idx, exp_b, k;
    bit  stall_seen, hs;

    initial begin
        reset = 1'b1; load_done = 0; ld_valid = 0; ld_addr = '0; ld_data = '0;
        nes_addr = '0; nes_rd_cpu = 0; nes_rd_ppu = 0; nes_wr = 0; nes_dout = '0;
        model_reset();
        pushed = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_phase", phase, 2'd0);
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_nesrst", nes_reset, 1'b1);
        chk("rst_we", sd_we, 1'b0);
        reset = 1'b0;

        // idle
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_we", sd_we, 1'b0);
        end

        // single byte pushed at phase 1
        k = 0;
        while (m_phase != 1 && k < 4) begin tick(); k++; end
        ld_valid = 1'b1; ld_addr = 22'h000010; ld_data = 8'hA5;
        tick();
        pushed++;
        ld_valid = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sd_we) begin
                hi_cnt++;
                chk("single_addr", sd_addr, 25'h0000010);
                chk("single_din", sd_din, 8'hA5);
            end
        end
        chk("single_hold", hi_cnt, 4);
        chk("single_cnt", wr_count, 1);

        // 6-byte burst with ld_valid held
        idx = 0; exp_b = 0; stall_seen = 0; k = 0;
        ld_valid = 1'b1; ld_addr = '0; ld_data = '0;
        while ((idx < 6 || m_q.size() > 0 || m_we) && k < 80) begin
            if (ld_valid && !ld_ready) stall_seen = 1;
            hs = model_accepts();
            tick();
            k++;
            if (hs) begin
                idx++; pushed++;
                ld_valid = (idx < 6);
                ld_addr = AB'(idx); ld_data = 8'(idx);
            end
            if (sd_we && phase == 2'd0) begin
                chk("burst_order", sd_din, 8'(exp_b));
                chk("burst_addr", sd_addr, 25'(exp_b));
                exp_b++;
            end
        end
        ld_valid = 1'b0;
        chk("burst_timeout", k < 80, 1'b1);
        chk("burst_stall", stall_seen, 1'b1);
        chk("burst_commits", exp_b, 6);
        chk("burst_cnt", wr_count, 7);

        // random loader traffic
        rand_traffic(200);
        drain_idle();
        chk("rand_cnt", wr_count, pushed);

        // two bytes queued, then load_done
        k = 0;
        while (m_phase != 0 && k < 4) begin tick(); k++; end
        ld_valid = 1'b1; new_byte(); tick(); pushed++;
        new_byte(); tick(); pushed++;
        ld_valid = 1'b0;
        load_done = 1'b1;
        tick();
        chk("drain_rdy0", ld_ready, 1'b0);
        ld_valid = 1'b1; new_byte();
        k = 0;
        while (nes_reset && k < 40) begin tick(); k++; end
        ld_valid = 1'b0;
        chk("run_timeout", k < 40, 1'b1);
        chk("run_phase0", phase, 2'd0);
        chk("drain_cnt", wr_count, pushed);

        // RUN pass-through
        nes_rd_cpu = 1'b1; nes_addr = 22'h123456;
        #1;
        chk("run_oeA", sd_oeA, 1'b1);
        chk("run_addr", sd_addr, 25'h0123456);
        chk("run_oeB", sd_oeB, 1'b0);
        nes_wr = 1'b1; nes_dout = 8'h3C;
        #1;
        chk("run_we", sd_we, 1'b1);
        chk("run_din", sd_din, 8'h3C);
        tick();
        for (int i = 0; i < 40; i++) begin
            nes_addr = AB'($urandom); nes_dout = 8'($urandom);
            nes_rd_cpu = 1'($urandom); nes_rd_ppu = 1'($urandom); nes_wr = 1'($urandom);
            ld_valid = 1'($urandom);
            tick();
        end
        ld_valid = 0; nes_rd_cpu = 0; nes_rd_ppu = 0; nes_wr = 0;

        // load_done falls: back to LOAD
        load_done = 1'b0;
        k = 0;
        while (!nes_reset && k < 20) begin tick(); k++; end
        chk("reload_timeout", k < 20, 1'b1);
        chk("reload_cnt", wr_count, 0);
        chk("reload_rdy", ld_ready, 1'b1);
        pushed = 0;
        rand_traffic(60);

        // reset in the middle of a write slot
        k = 0;
        ld_valid = 1'b1; new_byte();
        while (!(m_we && m_phase == 2) && k < 40) begin
            hs = model_accepts();
            tick();
            k++;
            if (hs) new_byte();
        end
        ld_valid = 1'b0;
        chk("prerst_timeout", k < 40, 1'b1);
        chk("prerst_we", sd_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_phase", phase, 2'd0);
        chk("arst_we", sd_we, 1'b0);
        chk("arst_addr", sd_addr, 25'd0);
        chk("arst_din", sd_din, 8'd0);
        chk("arst_cnt", wr_count, 0);
        chk("arst_nesrst", nes_reset, 1'b1);
        chk("arst_ready", ld_ready, 1'b1);
        chk("arst_runnes", run_nes, 1'b0);
        chk("arst_clkref", clkref, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sd_we) hi_cnt++;
        end
        chk("post_rst_nowrite", hi_cnt, 0);
        chk("post_rst_ready", ld_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
